rca32_accumulator: RTL and testbench
====================================

# rca32_accumulator

Streaming accumulator that sits directly downstream of the 32-bit ripple-carry adder and feeds it. Sums a burst of 32-bit operands, delimited by a last flag, into a running total. Each accepted operand is added to the accumulator through one `fulladdr_32_bit` instance with carry-in tied to 0. Adder carry-outs are counted into an 8-bit high word, so `{out_hi, out_sum}` is the exact 40-bit burst sum until saturation. The result is presented on a valid/ready output handshake.

## Interface
- `WIDTH`, 32: operand and accumulator width; only 32 is supported because the adder is fixed-width.
- `CNT_W`, 8: width of the operand counter and the carry (high-word) counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand present.
- `in_ready` out 1: block can accept an operand.
- `in_data` in WIDTH: operand.
- `in_last` in 1: qualifies `in_data` as the final operand of the burst.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out WIDTH: low 32 bits of the burst sum.
- `out_hi` out CNT_W: count of adder carry-outs (upper bits of the sum), saturating.
- `out_count` out CNT_W: number of operands accepted in the burst, saturating.
- `out_sat` out 1: set if `out_hi` or `out_count` saturated during the burst.

## Operation
- **States.**
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- **Adder connection.** The adder inputs are `acc` and `in_data`, with c_in=0. Its outputs (`sum`, `c_out`) are used only on an input handshake (`in_valid & in_ready`).
- **On an input handshake in ACC:**
  - `acc` <= `sum`.
  - `hi` <= `hi` + `c_out`, saturating at 2^CNT_W−1.
  - `count` <= `count` + 1, saturating.
  - `sat` is set sticky when either increment would wrap.
  - If `in_last`=1, go to HOLD.
- **In HOLD:**
  - Outputs are driven from the registers and stay stable while `out_ready`=0.
  - On `out_valid & out_ready`: clear `acc`, `hi`, `count` and `sat`, and return to ACC.
- **Zero-length burst.** `in_last` with no prior operands is a one-operand burst; `count`=1.
- **Simultaneous events.** Input and output handshakes cannot coincide, because `in_ready`=0 in HOLD.
- **Reset.**
  - `rst` has priority over every handshake in every state.
  - On the reset edge: state=ACC, `acc`=0, `hi`=0, `count`=0, `sat`=0.
  - Reset values of the outputs: `out_valid`=0, `in_ready`=1, `out_sum`=0, `out_hi`=0, `out_count`=0, `out_sat`=0.
  - Reset mid-burst discards the partial sum.

## Timing
- Input throughput: one operand per cycle in ACC.
- Latency: the last operand is accepted at edge t, `out_valid`=1 after edge t, and the result is stable from that point.
- Output handshake at edge u gives `in_ready`=1 after edge u. The minimum bubble between bursts is one cycle (the HOLD cycle).
- **Combinational path.** The 32-bit ripple from `acc` through the adder to `acc` is the critical path. There is no pipelining; the clock period must cover the full ripple.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `out_ready` or `in_valid` to them.

## Structure
- **Shared package (`rca_pkg`):** WIDTH and CNT_W defaults, plus the ACC/HOLD state encoding constants.
- **Sub-module:** one instance of the existing `fulladdr_32_bit`, ports in the order `(sum, c_out, a, b, c_in)`.
- **Top level:** the FSM, the `acc`/`hi`/`count`/`sat` registers and the handshake logic.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release → `in_ready`=1, `out_valid`=0, and all outputs 0 on the first cycle after reset.
- **Single operand:** `in_data`=0x00000001 with `in_last`=1 → next cycle `out_valid`=1, `out_sum`=0x00000001, `out_hi`=0, `out_count`=1, `out_sat`=0.
- **Two operands with carry:** 0xAFAFAAFF, then 0xAEBAEBFF with `in_last` → `out_sum`=0x5E6A96FE, `out_hi`=1, `out_count`=2.
- **Backpressure:** complete a burst, hold `out_ready`=0 for 5 cycles → `out_valid` stays 1, outputs stable, `in_ready`=0. Raise `out_ready` → the next cycle has `in_ready`=1 and `acc`=0.
- **Saturation:** 256 × 0xFFFFFFFF, `in_last` on the final operand → `out_sum`=0xFFFFFF00, `out_hi`=255, `out_count`=255, `out_sat`=1.
- **Mid-burst reset:** accept 3 operands (1, 2, 3), pulse `rst` 1 cycle, then send 5 with `in_last` → `out_sum`=5, `out_count`=1.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared sizing defaults and FSM state encoding for the ripple-carry accumulator.
package rca_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rca32_accumulator_fulladdr.sv
// 32-bit ripple-carry adder built from a chain of single-bit full adders.
module fulladdr_32_bit (
    output logic [31:0] sum,
    output logic        c_out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in
);

    logic [32:0] w_carry;

    assign w_carry[0] = c_in;

    // Explicit per-bit chain so the carry really ripples through all 32 cells.
    for (genvar g = 0; g < 32; g++) begin : g_bit
        assign sum[g]       = a[g] ^ b[g] ^ w_carry[g];
        assign w_carry[g+1] = (a[g] & b[g]) | (w_carry[g] & (a[g] ^ b[g]));
    end

    assign c_out = w_carry[32];

endmodule

// File: rtl/rca32_accumulator.sv
// Burst accumulator: sums operands through one ripple-carry adder and presents
// the 40-bit total (carry-count high word + low word) on a valid/ready output.
//
//  state   | meaning
//  ST_ACC  | accepting operands, in_ready=1
//  ST_HOLD | result presented, waiting for out_ready
module rca32_accumulator
    import rca_pkg::*;
#(
    parameter int WIDTH = rca_pkg::WIDTH,
    parameter int CNT_W = rca_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_hi,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic [WIDTH-1:0] w_sum;
    logic             w_c_out;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_hi_wrap;
    logic             w_cnt_wrap;

    fulladdr_32_bit u_adder (
        .sum   (w_sum),
        .c_out (w_c_out),
        .a     (r_acc),
        .b     (in_data),
        .c_in  (1'b0)
    );

    assign w_in_hs    = in_valid & in_ready;
    assign w_out_hs   = out_valid & out_ready;
    assign w_hi_wrap  = w_c_out & (r_hi == CNT_MAX);
    assign w_cnt_wrap = (r_count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_in_hs && in_last) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_out_hs)           w_state_nxt = ST_ACC;
            default:                         w_state_nxt = ST_ACC;
        endcase
    end

    // Handshake flags depend on the state register only, never on the peer's strobe.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_out_hs) begin
            r_acc   <= '0;
            r_hi    <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_in_hs) begin
            r_acc <= w_sum;
            if (w_c_out && !w_hi_wrap) begin
                r_hi <= r_hi + CNT_ONE;
            end
            if (!w_cnt_wrap) begin
                r_count <= r_count + CNT_ONE;
            end
            if (w_hi_wrap || w_cnt_wrap) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign out_sum   = r_acc;
    assign out_hi    = r_hi;
    assign out_count = r_count;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_rca32_accumulator.sv
// Scoreboard bench: input monitor builds expected burst totals with 64-bit
// arithmetic; output monitor pops and compares on each output handshake.
module tb_rca32_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [7:0]  out_hi;
    logic [7:0]  out_count;
    logic        out_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  hi;
        logic [7:0]  cnt;
        logic        sat;
    } exp_t;

    exp_t q[$];
    longint unsigned m_total = 0;
    int              m_cnt   = 0;

    logic rand_bp = 1'b0;
    logic bp_hold = 1'b1;
    logic r_rand  = 1'b1;

    assign out_ready = rand_bp ? r_rand : bp_hold;

    always #5 clk = ~clk;

    rca32_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_hi    (out_hi),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) r_rand <= ($urandom_range(0, 3) != 0);

    // Reference model: exact burst total, then saturate the reported fields.
    always @(posedge clk) begin
        if (rst) begin
            m_total = 0;
            m_cnt   = 0;
            q.delete();
        end else if (in_valid && in_ready) begin
            m_total += 64'(in_data);
            m_cnt++;
            if (in_last) begin
                exp_t e;
                longint unsigned c;
                c     = m_total >> 32;
                e.sum = m_total[31:0];
                e.hi  = (c > 255) ? 8'hFF : 8'(c);
                e.cnt = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
                e.sat = (c > 255) || (m_cnt > 255);
                q.push_back(e);
                m_total = 0;
                m_cnt   = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            chk("ready_vs_valid", 64'(in_ready), 64'(!out_valid));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_sum",   64'(out_sum),   64'(e.sum));
                    chk("out_hi",    64'(out_hi),    64'(e.hi));
                    chk("out_count", 64'(out_count), 64'(e.cnt));
                    chk("out_sat",   64'(out_sat),   64'(e.sat));
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !in_ready) chk("idle_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum",   64'(out_sum),   64'(0));
        chk("rst_out_hi",    64'(out_hi),    64'(0));
        chk("rst_out_count", 64'(out_count), 64'(0));
        chk("rst_out_sat",   64'(out_sat),   64'(0));

        send(32'h0000_0001, 1'b1);
        wait_idle();

        send(32'hAFAF_AAFF, 1'b0);
        send(32'hAEBA_EBFF, 1'b1);
        wait_idle();

        // Backpressure: hold the result for five cycles.
        bp_hold = 1'b0;
        send(32'd7, 1'b0);
        send(32'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready",  64'(in_ready),  64'(0));
            chk("bp_out_sum",   64'(out_sum),   64'(16));
            chk("bp_out_count", 64'(out_count), 64'(2));
        end
        bp_hold = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_in_ready",  64'(in_ready),  64'(1));
        chk("post_hs_out_valid", 64'(out_valid), 64'(0));
        chk("post_hs_acc",       64'(out_sum),   64'(0));
        chk("post_hs_count",     64'(out_count), 64'(0));

        for (int i = 0; i < 256; i++) send(32'hFFFF_FFFF, i == 255);
        wait_idle();

        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sum",   64'(out_sum),   64'(0));
        chk("midrst_count", 64'(out_count), 64'(0));
        send(32'd5, 1'b1);
        wait_idle();

        rand_bp = 1'b1;
        for (int b = 0; b < 40; b++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                logic [31:0] d;
                case ($urandom_range(0, 3))
                    0:       d = 32'hFFFF_FFFF;
                    1:       d = 32'($urandom_range(0, 255));
                    default: d = $urandom;
                endcase
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                send(d, k == len - 1);
            end
        end
        wait_idle();
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
